osc_bank: RTL and testbench
===========================

# osc_bank

Parametrised multi-voice oscillator bank for the AudioVoice synth path. It generates NUM_VOICES independent triangle, sawtooth, square or variable-duty pulse waveforms from per-voice phase accumulators, time-multiplexing one shared waveform shaper. On each sample-rate tick it emits one sample per voice, in voice order, over a valid/ready stream to the downstream filter/mixer.

## Interface
- DATA_W, 16, sample width; also the number of phase MSBs fed to the shaper
- PHASE_W, 24, phase accumulator width (≥ DATA_W)
- NUM_VOICES, 4, voice count (≥ 2); VOICE_W = $clog2(NUM_VOICES)
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- sample_tick  in  1  one-cycle pulse at the audio sample rate; starts a frame
- cfg_we  in  1  write strobe for the voice configuration
- cfg_voice  in  VOICE_W  voice addressed by cfg_we
- cfg_mode  in  2  0 triangle, 1 sawtooth, 2 square, 3 pulse
- cfg_incr  in  PHASE_W  phase increment per frame
- cfg_duty  in  DATA_W  pulse threshold (mode 3 only)
- voice_sync  in  NUM_VOICES  per-voice phase clear (hard sync)
- out_valid  out  1  sample available
- out_ready  in  1  downstream accepts the sample
- out_voice  out  VOICE_W  voice index of out_sample
- out_sample  out  DATA_W  sample value
- overrun  out  1  sticky: a tick arrived while a frame was in progress

## Operation
- Per-voice registers: phase[PHASE_W], incr, mode, duty. Reset values: phase 0, incr 0, mode 0, duty 2^(DATA_W-1).
- cfg_we writes incr, mode and duty of cfg_voice at the clock edge.
- FSM states: IDLE, CALC, OUT.
  - IDLE: when sample_tick is high, set voice=0 and go to CALC.
  - CALC: p = phase[voice][PHASE_W-1 -: DATA_W], taken from the pre-update phase. Register out_sample=shape(p), register out_voice=voice, set phase[voice] += incr (mod 2^PHASE_W), set out_valid=1, go to OUT.
  - OUT: hold out_valid, out_voice and out_sample stable until out_ready. On acceptance, clear out_valid. If voice == NUM_VOICES-1 go to IDLE; otherwise increment voice and go to CALC.
- Shaper, with s = {p[DATA_W-2:0],1'b0}:
  - triangle: s if p MSB is 0, else ~s
  - sawtooth: p
  - square: all-ones if p < 2^(DATA_W-1), else 0
  - pulse: all-ones if p < duty, else 0. duty 0 gives constant 0.
- Boundary rules:
  - sample_tick while not in IDLE: the tick is dropped, overrun is set (sticky until reset), and the current frame continues.
  - voice_sync[v] sets phase[v] to 0. It has priority over the CALC update of the same voice in the same cycle.
  - cfg_we in the same cycle as CALC of that voice: CALC uses the old values; the new values apply from the next frame.
  - Phase wrap is silent, modulo 2^PHASE_W.
- Reset (including mid-frame): state IDLE, voice 0, out_valid 0, out_voice 0, out_sample 0, overrun 0, all voice registers at their reset values. An in-flight frame is abandoned.

## Timing
- sample_tick in cycle t → CALC in t+1 → out_valid high from t+2.
- With out_ready held high, voices follow every 2 cycles; a full frame takes 2·NUM_VOICES cycles after the tick.
- The minimum tick spacing without overrun is 2·NUM_VOICES+1 cycles.
- out_valid never drops without a handshake, except under reset.

## Configuration
- OSC_BANK_ZERO_CENTER_EN defined: out_sample is two's-complement, zero-centred; the shaper output MSB is inverted before registering.
- OSC_BANK_ZERO_CENTER_EN undefined: out_sample is unsigned with a 2^(DATA_W-1) offset, exactly as the shaper produces it.

## Structure
- Package osc_bank_pkg holds:
  - enum wave_mode_e: TRI=0, SAW=1, SQR=2, PULSE=3
  - enum osc_state_e: IDLE, CALC, OUT
- Sub-module osc_wave_shaper: combinational, (p, mode, duty) → sample, parametrised by DATA_W.
- The FSM, voice register file and accumulator live in the top level.

## Test plan
All scenarios use default parameters with OSC_BANK_ZERO_CENTER_EN undefined.
- Reset, then one tick with all voices at reset config → out_voice 0,1,2,3, out_sample 0x0000 each; out_valid first high 2 cycles after the tick; overrun 0.
- Voice 1: saw, incr 0x100000; 17 ticks → voice-1 samples 0x0000, 0x1000, …, 0xF000, then wrap to 0x0000.
- Voice 2: triangle, incr 0x200000 → samples 0x0000, 0x4000, 0x8000, 0xC000, 0xFFFF, 0xBFFF, 0x7FFF, 0x3FFF, then repeat.
- Voice 3: pulse, duty 0x4000, incr 0x100000 → 4 samples of 0xFFFF, then 12 samples of 0x0000, per 16-tick period.
- out_ready low for 10 cycles mid-frame, plus a second tick during the frame → out_valid/out_sample/out_voice stable throughout; overrun goes to 1; the frame completes exactly once.
- voice_sync[1] asserted between ticks while voice 1 is at phase 0x700000 → next voice-1 sample 0x0000; resetn low mid-frame → out_valid 0 on the next cycle.

Source files
------------

// File: rtl/osc_bank_pkg.sv
// -----------------------------------------------------------------------------
// osc_bank_pkg
// Shared types for the oscillator bank: waveform mode encoding and the
// frame-sequencer state encoding.
// -----------------------------------------------------------------------------
package osc_bank_pkg;

    // Waveform selected per voice; encoding matches the cfg_mode input.
    typedef enum logic [1:0] {
        TRI   = 2'd0,
        SAW   = 2'd1,
        SQR   = 2'd2,
        PULSE = 2'd3
    } wave_mode_e;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } osc_state_e;

    // Reset value of the pulse threshold: half scale (2^(w-1)).
    function automatic logic [31:0] half_scale(input int unsigned w);
        logic [31:0] v;
        v = 32'd1 << (w - 32'd1);
        return v;
    endfunction

endpackage

// File: rtl/osc_wave_shaper.sv
// -----------------------------------------------------------------------------
// osc_wave_shaper
// Combinational waveform shaper shared by all voices. Maps the top DATA_W
// phase bits to an unsigned sample (mid-scale offset of 2^(DATA_W-1)).
// Ports:
//   p_i      phase MSBs of the voice being computed
//   mode_i   waveform selection
//   duty_i   pulse threshold (pulse mode only)
//   sample_o shaped unsigned sample
// -----------------------------------------------------------------------------
module osc_wave_shaper
    import osc_bank_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] p_i,
    input  wave_mode_e        mode_i,
    input  logic [DATA_W-1:0] duty_i,
    output logic [DATA_W-1:0] sample_o
);

    logic [DATA_W-1:0] s_s;

    // Waveform selection; triangle folds the doubled ramp on the phase MSB.
    always_comb begin
        s_s      = {p_i[DATA_W-2:0], 1'b0};
        sample_o = {DATA_W{1'b0}};
        case (mode_i)
            TRI: begin
                if (p_i[DATA_W-1]) begin
                    sample_o = ~s_s;
                end else begin
                    sample_o = s_s;
                end
            end
            SAW: begin
                sample_o = p_i;
            end
            SQR: begin
                // p < 2^(DATA_W-1) is exactly "MSB clear"
                if (p_i[DATA_W-1]) begin
                    sample_o = {DATA_W{1'b0}};
                end else begin
                    sample_o = {DATA_W{1'b1}};
                end
            end
            PULSE: begin
                // duty 0 never satisfies p < duty, giving constant 0
                if (p_i < duty_i) begin
                    sample_o = {DATA_W{1'b1}};
                end else begin
                    sample_o = {DATA_W{1'b0}};
                end
            end
            default: begin
                sample_o = {DATA_W{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/osc_bank.sv
// -----------------------------------------------------------------------------
// osc_bank
// Multi-voice oscillator bank. Each sample_tick starts a frame that walks the
// voices in order; for each voice the shared shaper converts the pre-update
// phase into a sample, the phase advances by its increment, and the sample is
// offered on a valid/ready stream.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   sample_tick        frame start pulse (dropped and flagged if busy)
//   cfg_we/cfg_voice   configuration write strobe and target voice
//   cfg_mode/incr/duty waveform, phase increment, pulse threshold
//   voice_sync         per-voice phase clear (hard sync)
//   out_valid/ready    sample stream handshake
//   out_voice/sample   voice index and sample value
//   overrun            sticky: tick seen while a frame was in progress
// Build option: OSC_BANK_ZERO_CENTER_EN makes out_sample two's-complement
// (shaper MSB inverted); otherwise out_sample is offset-binary.
// -----------------------------------------------------------------------------
module osc_bank
    import osc_bank_pkg::*;
#(
    parameter  int DATA_W     = 16,
    parameter  int PHASE_W    = 24,
    parameter  int NUM_VOICES = 4,
    localparam int VOICE_W    = $clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  sample_tick,
    input  logic                  cfg_we,
    input  logic [VOICE_W-1:0]    cfg_voice,
    input  logic [1:0]            cfg_mode,
    input  logic [PHASE_W-1:0]    cfg_incr,
    input  logic [DATA_W-1:0]     cfg_duty,
    input  logic [NUM_VOICES-1:0] voice_sync,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [VOICE_W-1:0]    out_voice,
    output logic [DATA_W-1:0]     out_sample,
    output logic                  overrun
);

    localparam logic [VOICE_W-1:0] LAST_VOICE = VOICE_W'(NUM_VOICES - 1);
    localparam logic [DATA_W-1:0]  DUTY_RST   = DATA_W'(half_scale(DATA_W));

    osc_state_e          state_q, state_d;
    logic [VOICE_W-1:0]  voice_q, voice_d;
    logic                out_valid_q, out_valid_d;
    logic [VOICE_W-1:0]  out_voice_q, out_voice_d;
    logic [DATA_W-1:0]   out_sample_q, out_sample_d;
    logic                overrun_q, overrun_d;

    logic [PHASE_W-1:0]  phase_q [NUM_VOICES];
    logic [PHASE_W-1:0]  phase_d [NUM_VOICES];
    logic [PHASE_W-1:0]  incr_q  [NUM_VOICES];
    logic [PHASE_W-1:0]  incr_d  [NUM_VOICES];
    wave_mode_e          mode_q  [NUM_VOICES];
    wave_mode_e          mode_d  [NUM_VOICES];
    logic [DATA_W-1:0]   duty_q  [NUM_VOICES];
    logic [DATA_W-1:0]   duty_d  [NUM_VOICES];

    logic [DATA_W-1:0]   shp_p_s;
    logic [DATA_W-1:0]   shp_out_s;
    logic [DATA_W-1:0]   shaped_s;

    // Shaper always looks at the current voice's pre-update phase.
    assign shp_p_s = phase_q[voice_q][PHASE_W-1 -: DATA_W];

    osc_wave_shaper #(
        .DATA_W (DATA_W)
    ) u_shaper (
        .p_i      (shp_p_s),
        .mode_i   (mode_q[voice_q]),
        .duty_i   (duty_q[voice_q]),
        .sample_o (shp_out_s)
    );

`ifdef OSC_BANK_ZERO_CENTER_EN
    // Flipping the MSB turns offset-binary into two's-complement.
    assign shaped_s = {~shp_out_s[DATA_W-1], shp_out_s[DATA_W-2:0]};
`else
    assign shaped_s = shp_out_s;
`endif

    // Next-state logic: sequencer, output staging, voice registers.
    always_comb begin
        state_d      = state_q;
        voice_d      = voice_q;
        out_valid_d  = out_valid_q;
        out_voice_d  = out_voice_q;
        out_sample_d = out_sample_q;
        overrun_d    = overrun_q;
        phase_d      = phase_q;
        incr_d       = incr_q;
        mode_d       = mode_q;
        duty_d       = duty_q;

        if (sample_tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        // Config lands in the registers; an in-progress CALC already used the old values.
        if (cfg_we) begin
            incr_d[cfg_voice] = cfg_incr;
            mode_d[cfg_voice] = wave_mode_e'(cfg_mode);
            duty_d[cfg_voice] = cfg_duty;
        end else begin
            incr_d = incr_q;
        end

        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    voice_d = {VOICE_W{1'b0}};
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                out_sample_d     = shaped_s;
                out_voice_d      = voice_q;
                out_valid_d      = 1'b1;
                phase_d[voice_q] = phase_q[voice_q] + incr_q[voice_q];
                state_d          = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (voice_q == LAST_VOICE) begin
                        state_d = IDLE;
                    end else begin
                        voice_d = voice_q + VOICE_W'(1);
                        state_d = CALC;
                    end
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Hard sync applied last so it overrides the CALC increment.
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_sync[v]) begin
                phase_d[v] = {PHASE_W{1'b0}};
            end else begin
                phase_d[v] = phase_d[v];
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            voice_q      <= {VOICE_W{1'b0}};
            out_valid_q  <= 1'b0;
            out_voice_q  <= {VOICE_W{1'b0}};
            out_sample_q <= {DATA_W{1'b0}};
            overrun_q    <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v] <= {PHASE_W{1'b0}};
                incr_q[v]  <= {PHASE_W{1'b0}};
                mode_q[v]  <= TRI;
                duty_q[v]  <= DUTY_RST;
            end
        end else begin
            state_q      <= state_d;
            voice_q      <= voice_d;
            out_valid_q  <= out_valid_d;
            out_voice_q  <= out_voice_d;
            out_sample_q <= out_sample_d;
            overrun_q    <= overrun_d;
            phase_q      <= phase_d;
            incr_q       <= incr_d;
            mode_q       <= mode_d;
            duty_q       <= duty_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_voice  = out_voice_q;
    assign out_sample = out_sample_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_osc_bank.sv
// -----------------------------------------------------------------------------
// tb_osc_bank
// Directed self-checking bench for osc_bank at default parameters with the
// offset-binary output format.
// -----------------------------------------------------------------------------
module tb_osc_bank;
    import osc_bank_pkg::*;

    localparam int DATA_W     = 16;
    localparam int PHASE_W    = 24;
    localparam int NUM_VOICES = 4;
    localparam int VOICE_W    = 2;

    logic                  clk;
    logic                  resetn;
    logic                  sample_tick;
    logic                  cfg_we;
    logic [VOICE_W-1:0]    cfg_voice;
    logic [1:0]            cfg_mode;
    logic [PHASE_W-1:0]    cfg_incr;
    logic [DATA_W-1:0]     cfg_duty;
    logic [NUM_VOICES-1:0] voice_sync;
    logic                  out_valid;
    logic                  out_ready;
    logic [VOICE_W-1:0]    out_voice;
    logic [DATA_W-1:0]     out_sample;
    logic                  overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    int          got_n;
    int          first_lat;
    logic [31:0] got_v [NUM_VOICES];
    logic [31:0] got_s [NUM_VOICES];
    logic [31:0] exp_s [NUM_VOICES];
    logic [15:0] tri_tab [8];

    osc_bank dut (
        .clk         (clk),
        .resetn      (resetn),
        .sample_tick (sample_tick),
        .cfg_we      (cfg_we),
        .cfg_voice   (cfg_voice),
        .cfg_mode    (cfg_mode),
        .cfg_incr    (cfg_incr),
        .cfg_duty    (cfg_duty),
        .voice_sync  (voice_sync),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_voice   (out_voice),
        .out_sample  (out_sample),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, expv);
            $error("%s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic cfg_write(input int v, input logic [1:0] m, input logic [23:0] inc, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_voice = VOICE_W'(v);
        cfg_mode  = m;
        cfg_incr  = inc;
        cfg_duty  = d;
        step();
        cfg_we    = 1'b0;
    endtask

    // Issue one tick with out_ready high and record every accepted sample.
    task automatic collect_frame();
        int cyc;
        got_n     = 0;
        first_lat = -1;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        cyc = 1;
        while (got_n < NUM_VOICES && cyc < 60) begin
            step();
            cyc++;
            if (out_valid && first_lat < 0) first_lat = cyc;
            if (out_valid && out_ready) begin
                got_v[got_n] = 32'(out_voice);
                got_s[got_n] = 32'(out_sample);
                got_n++;
            end
        end
        chk("frame_count", 32'(got_n), 32'(NUM_VOICES));
        step();
        step();
    endtask

    task automatic check_frame(input string tag);
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (i < got_n) begin
                chk({tag, "_voice"}, got_v[i], 32'(i));
                chk({tag, "_sample"}, got_s[i], exp_s[i]);
            end
        end
    endtask

    initial begin
        int kf;
        int v1k;
        int extra;
        int cyc;

        tri_tab[0] = 16'h0000; tri_tab[1] = 16'h4000;
        tri_tab[2] = 16'h8000; tri_tab[3] = 16'hC000;
        tri_tab[4] = 16'hFFFF; tri_tab[5] = 16'hBFFF;
        tri_tab[6] = 16'h7FFF; tri_tab[7] = 16'h3FFF;

        resetn      = 1'b0;
        sample_tick = 1'b0;
        cfg_we      = 1'b0;
        cfg_voice   = 2'd0;
        cfg_mode    = 2'd0;
        cfg_incr    = 24'd0;
        cfg_duty    = 16'd0;
        voice_sync  = 4'd0;
        out_ready   = 1'b1;
        repeat (3) step();
        chk("rst_valid",   32'(out_valid),  32'd0);
        chk("rst_voice",   32'(out_voice),  32'd0);
        chk("rst_sample",  32'(out_sample), 32'd0);
        chk("rst_overrun", 32'(overrun),    32'd0);
        resetn = 1'b1;
        step();

        // Reset configuration: every voice yields 0.
        collect_frame();
        chk("first_latency", 32'(first_lat), 32'd2);
        for (int i = 0; i < NUM_VOICES; i++) exp_s[i] = 32'h0;
        check_frame("rstcfg");
        chk("overrun_idle", 32'(overrun), 32'd0);

        cfg_write(1, 2'd1, 24'h100000, 16'h8000);
        cfg_write(2, 2'd0, 24'h200000, 16'h8000);
        cfg_write(3, 2'd3, 24'h100000, 16'h4000);

        // 17 frames: saw wraps, triangle repeats every 8, pulse 4-high of 16.
        for (int k = 0; k < 17; k++) begin
            collect_frame();
            exp_s[0] = 32'h0;
            exp_s[1] = 32'((k * 32'h1000) & 32'hFFFF);
            exp_s[2] = 32'(tri_tab[k % 8]);
            exp_s[3] = ((k % 16) < 4) ? 32'hFFFF : 32'h0000;
            check_frame("wave");
        end
        chk("overrun_spaced", 32'(overrun), 32'd0);

        // Frame k=17 with a 10-cycle stall and a dropped tick.
        out_ready   = 1'b0;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        chk("stall_valid0", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            sample_tick = (i == 3) ? 1'b1 : 1'b0;
            step();
            chk("stall_valid",  32'(out_valid),  32'd1);
            chk("stall_voice",  32'(out_voice),  32'd0);
            chk("stall_sample", 32'(out_sample), 32'd0);
        end
        sample_tick = 1'b0;
        chk("overrun_set", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        got_n = 0;
        cyc   = 0;
        do begin
            if (out_valid && out_ready) begin
                got_v[got_n] = 32'(out_voice);
                got_s[got_n] = 32'(out_sample);
                got_n++;
            end
            step();
            cyc++;
        end while (got_n < NUM_VOICES && cyc < 40);
        chk("stall_count", 32'(got_n), 32'(NUM_VOICES));
        exp_s[0] = 32'h0000;
        exp_s[1] = 32'h1000;
        exp_s[2] = 32'(tri_tab[17 % 8]);
        exp_s[3] = 32'hFFFF;
        check_frame("stall");
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (out_valid) extra++;
        end
        chk("no_extra_frame", 32'(extra), 32'd0);

        // Hard sync voice 1, run to phase 0x700000, sync again.
        voice_sync = 4'b0010;
        step();
        voice_sync = 4'b0000;
        kf  = 18;
        v1k = 0;
        for (int j = 0; j < 8; j++) begin
            if (j == 7) begin
                voice_sync = 4'b0010;
                step();
                voice_sync = 4'b0000;
                v1k = 0;
            end
            collect_frame();
            exp_s[0] = 32'h0;
            exp_s[1] = 32'((v1k * 32'h1000) & 32'hFFFF);
            exp_s[2] = 32'(tri_tab[kf % 8]);
            exp_s[3] = ((kf % 16) < 4) ? 32'hFFFF : 32'h0000;
            check_frame("sync");
            kf++;
            v1k++;
        end
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of a frame.
        out_ready   = 1'b0;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        resetn = 1'b0;
        step();
        chk("midrst_valid",   32'(out_valid),  32'd0);
        chk("midrst_overrun", 32'(overrun),    32'd0);
        chk("midrst_sample",  32'(out_sample), 32'd0);
        chk("midrst_voice",   32'(out_voice),  32'd0);
        resetn    = 1'b1;
        out_ready = 1'b1;
        step();
        for (int f = 0; f < 2; f++) begin
            collect_frame();
            for (int i = 0; i < NUM_VOICES; i++) exp_s[i] = 32'h0;
            check_frame("postrst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
